alu_issue: RTL and testbench

Decode-to-execute issue stage for the RV32 core: accepts a fetched instruction with its PC and register-file read data, decodes it into `ALU_*` opcode and `srcA`/`srcB` operands for the ALU, and holds the result in a registered valid/ready pipeline slot with a one-entry skid buffer. It is the producer side of the ALU operand/opcode interface and sits between fetch/register-file read and the execute stage.

---
 rtl/alu_issue.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_issue.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Decode-to-execute issue stage: RV32 decode into ALU opcode/operands behind a
// registered valid/ready slot with a one-entry skid. Define ALU_ISSUE_ILLEGAL_EN to flag illegal encodings.

`ifndef ALU_DEFINES_SVH
`define ALU_DEFINES_SVH
`define ALU_OPCODE_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_BEQ  4'd10
`define ALU_BNE  4'd11
`define ALU_BLT  4'd12
`define ALU_BGE  4'd13
`define ALU_BLTU 4'd14
`define ALU_BGEU 4'd15
`endif

module alu_issue (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  instr,
    input  logic [31:0]                  pc,
    output logic [4:0]                   rs1_addr,
    output logic [4:0]                   rs2_addr,
    input  logic [31:0]                  rs1_data,
    input  logic [31:0]                  rs2_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [`ALU_OPCODE_WIDTH-1:0] alu_opcode,
    output logic [31:0]                  srcA,
    output logic [31:0]                  srcB,
    output logic [4:0]                   rd_addr,
    output logic                         rd_we,
    output logic                         is_branch,
    output logic                         is_jump,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic                         illegal,
    output logic [31:0]                  store_data
);

    typedef struct packed {
        logic [`ALU_OPCODE_WIDTH-1:0] opcode;
        logic [31:0]                  src_a;
        logic [31:0]                  src_b;
        logic [4:0]                   rd_addr;
        logic                         rd_we;
        logic                         is_branch;
        logic                         is_jump;
        logic                         mem_read;
        logic                         mem_write;
        logic                         illegal;
        logic [31:0]                  store_data;
    } slot_t;

    slot_t       dec, main_slot, skid_slot;
    logic        main_valid, skid_valid, accept, bad;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_u, shamt;

    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u    = {instr[31:12], 12'b0};
    assign shamt    = {27'b0, instr[24:20]};

    function automatic logic [`ALU_OPCODE_WIDTH-1:0] arith_op(input logic [2:0] f3);
        case (f3)
            3'b000:  arith_op = `ALU_ADD;
            3'b001:  arith_op = `ALU_SLL;
            3'b010:  arith_op = `ALU_SLT;
            3'b011:  arith_op = `ALU_SLTU;
            3'b100:  arith_op = `ALU_XOR;
            3'b101:  arith_op = `ALU_SRL;
            3'b110:  arith_op = `ALU_OR;
            default: arith_op = `ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec         = '0;
        dec.opcode  = `ALU_ADD;
        dec.rd_addr = instr[11:7];
        bad         = 1'b0;
        case (instr[6:0])
            7'b0110011: begin
                dec.src_a = rs1_data;
                dec.src_b = rs2_data;
                dec.rd_we = 1'b1;
                if (funct7 == 7'b0000000)
                    dec.opcode = arith_op(funct3);
                else if (funct7 == 7'b0100000 && funct3 == 3'b000)
                    dec.opcode = `ALU_SUB;
                else if (funct7 == 7'b0100000 && funct3 == 3'b101)
                    dec.opcode = `ALU_SRA;
                else
                    bad = 1'b1;
            end
            7'b0010011: begin
                dec.src_a  = rs1_data;
                dec.src_b  = imm_i;
                dec.rd_we  = 1'b1;
                dec.opcode = arith_op(funct3);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.src_b = shamt;
                    if (funct3 == 3'b101 && funct7 == 7'b0100000)
                        dec.opcode = `ALU_SRA;
                    else if (funct7 != 7'b0000000)
                        bad = 1'b1;
                end
            end
            7'b0110111: begin
                dec.src_b = imm_u;
                dec.rd_we = 1'b1;
            end
            7'b0010111: begin
                dec.src_a = pc;
                dec.src_b = imm_u;
                dec.rd_we = 1'b1;
            end
            7'b1101111, 7'b1100111: begin
                dec.src_a   = pc;
                dec.src_b   = 32'd4;
                dec.rd_we   = 1'b1;
                dec.is_jump = 1'b1;
            end
            7'b0000011: begin
                dec.src_a    = rs1_data;
                dec.src_b    = imm_i;
                dec.rd_we    = 1'b1;
                dec.mem_read = 1'b1;
            end
            7'b0100011: begin
                dec.src_a      = rs1_data;
                dec.src_b      = imm_s;
                dec.mem_write  = 1'b1;
                dec.store_data = rs2_data;
            end
            7'b1100011: begin
                dec.src_a     = rs1_data;
                dec.src_b     = rs2_data;
                dec.is_branch = 1'b1;
                case (funct3)
                    3'b000:  dec.opcode = `ALU_BEQ;
                    3'b001:  dec.opcode = `ALU_BNE;
                    3'b100:  dec.opcode = `ALU_BLT;
                    3'b101:  dec.opcode = `ALU_BGE;
                    3'b110:  dec.opcode = `ALU_BLTU;
                    3'b111:  dec.opcode = `ALU_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        // Illegal encodings collapse to an all-zero ADD; only the flag differs by build.
        if (bad) begin
            dec        = '0;
            dec.opcode = `ALU_ADD;
`ifdef ALU_ISSUE_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
        end
        if (dec.rd_addr == 5'd0)
            dec.rd_we = 1'b0;
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid       <= 1'b0;
            skid_valid       <= 1'b0;
            main_slot        <= '0;
            main_slot.opcode <= `ALU_ADD;
            skid_slot        <= '0;
            skid_slot.opcode <= `ALU_ADD;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_valid && !out_ready) begin
            // Main slot stalled: the one accept allowed here lands in the skid.
            if (accept) begin
                skid_slot  <= dec;
                skid_valid <= 1'b1;
            end
        end else if (skid_valid) begin
            main_slot  <= skid_slot;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
        end else if (accept) begin
            main_slot  <= dec;
            main_valid <= 1'b1;
        end else begin
            main_valid <= 1'b0;
        end
    end

    assign out_valid  = main_valid;
    assign alu_opcode = main_slot.opcode;
    assign srcA       = main_slot.src_a;
    assign srcB       = main_slot.src_b;
    assign rd_addr    = main_slot.rd_addr;
    assign rd_we      = main_slot.rd_we;
    assign is_branch  = main_slot.is_branch;
    assign is_jump    = main_slot.is_jump;
    assign mem_read   = main_slot.mem_read;
    assign mem_write  = main_slot.mem_write;
    assign illegal    = main_slot.illegal;
    assign store_data = main_slot.store_data;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed decode cases, stall/skid, flush,
// illegal handling and a randomized stream against a queue-based reference model.

module tb_alu_issue;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SLL = 4'd2,  OP_SLT = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4, OP_XOR = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
    localparam logic [3:0] OP_OR = 4'd8,   OP_AND = 4'd9,  OP_BEQ = 4'd10, OP_BNE = 4'd11;
    localparam logic [3:0] OP_BLT = 4'd12, OP_BGE = 4'd13, OP_BLTU = 4'd14, OP_BGEU = 4'd15;
    localparam logic [3:0] ARITH [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    localparam logic [3:0] BRANCH [8] = '{OP_BEQ, OP_BNE, OP_ADD, OP_ADD, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data, srcA, srcB, store_data;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_opcode;
    logic        rd_we, is_branch, is_jump, mem_read, mem_write, illegal;

    int checks = 0;
    int errors = 0;
    bit track  = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, sd;
        logic [4:0]  rd;
        logic        we, br, jp, mr, mw, ill;
    } exp_t;

    exp_t q[$];

    alu_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_opcode(alu_opcode), .srcA(srcA), .srcB(srcB),
        .rd_addr(rd_addr), .rd_we(rd_we),
        .is_branch(is_branch), .is_jump(is_jump),
        .mem_read(mem_read), .mem_write(mem_write),
        .illegal(illegal), .store_data(store_data)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        bit bad = 1'b0;
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        logic [31:0] imm_i = 32'($signed(i) >>> 20);
        logic [31:0] imm_s = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
        logic [31:0] imm_u = i & 32'hFFFF_F000;
        e.op = OP_ADD; e.a = '0; e.b = '0; e.sd = '0; e.rd = i[11:7];
        e.we = 0; e.br = 0; e.jp = 0; e.mr = 0; e.mw = 0; e.ill = 0;
        case (i[6:0])
            7'h33: begin
                e.a = r1; e.b = r2; e.we = 1;
                if (f7 == 7'h00) e.op = ARITH[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.op = OP_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) e.op = OP_SRA;
                else bad = 1;
            end
            7'h13: begin
                e.a = r1; e.we = 1; e.op = ARITH[f3]; e.b = imm_i;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = imm_i & 32'h1F;
                    if (f3 == 3'd5 && f7 == 7'h20) e.op = OP_SRA;
                    else if (f7 != 7'h00) bad = 1;
                end
            end
            7'h37: begin e.b = imm_u; e.we = 1; end
            7'h17: begin e.a = p; e.b = imm_u; e.we = 1; end
            7'h6F, 7'h67: begin e.a = p; e.b = 4; e.we = 1; e.jp = 1; end
            7'h03: begin e.a = r1; e.b = imm_i; e.we = 1; e.mr = 1; end
            7'h23: begin e.a = r1; e.b = imm_s; e.mw = 1; e.sd = r2; end
            7'h63: begin
                e.a = r1; e.b = r2; e.br = 1; e.op = BRANCH[f3];
                if (f3 == 3'd2 || f3 == 3'd3) bad = 1;
            end
            default: bad = 1;
        endcase
        if (bad) begin
            e.op = OP_ADD; e.a = '0; e.b = '0; e.sd = '0; e.rd = '0;
            e.we = 0; e.br = 0; e.jp = 0; e.mr = 0; e.mw = 0; e.ill = ILL_EN;
        end
        if (e.rd == 5'd0) e.we = 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int unsigned k = $urandom_range(0, 10);
        case (k)
            0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;  4: r[6:0] = 7'h6F;  5: r[6:0] = 7'h67;
            6: r[6:0] = 7'h03;  7: r[6:0] = 7'h23;  8, 9: r[6:0] = 7'h63;
            default: r[6:0] = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h0B;
        endcase
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
            k = $urandom_range(0, 5);
            if (k <= 2) r[31:25] = 7'h00;
            else if (k <= 4) r[31:25] = 7'h20;
        end
        return r;
    endfunction

    // One clock: check visible state against the model, apply this cycle's handshakes, advance.
    task automatic step();
        bit fin, fout;
        exp_t e;
        if (track) begin
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL handshake: out_valid=%b in_ready=%b, required %b %b",
                         out_valid, in_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0 && out_valid === 1'b1) begin
                e = q[0];
                checks++;
                if ({alu_opcode, srcA, srcB, rd_addr, rd_we, is_branch, is_jump, mem_read,
                     mem_write, illegal, store_data} !==
                    {e.op, e.a, e.b, e.rd, e.we, e.br, e.jp, e.mr, e.mw, e.ill, e.sd}) begin
                    errors++;
                    $display("FAIL issue_out: got op=%0d a=%h b=%h rd=%0d we=%b br=%b j=%b mr=%b mw=%b ill=%b sd=%h; want op=%0d a=%h b=%h rd=%0d we=%b br=%b j=%b mr=%b mw=%b ill=%b sd=%h",
                             alu_opcode, srcA, srcB, rd_addr, rd_we, is_branch, is_jump, mem_read, mem_write, illegal, store_data,
                             e.op, e.a, e.b, e.rd, e.we, e.br, e.jp, e.mr, e.mw, e.ill, e.sd);
                end
            end
        end
        fin  = in_valid && (q.size() < 2);
        fout = out_ready && (q.size() > 0);
        if (rst || flush) q.delete();
        else begin
            if (fout) void'(q.pop_front());
            if (fin) q.push_back(model(instr, pc, rs1_data, rs2_data));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 1; out_ready = 0;
        instr = 32'h002081B3; pc = 32'h40; rs1_data = 32'h11; rs2_data = 32'h22;
        repeat (3) @(posedge clk);
        #1;
        rst = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (alu_opcode !== OP_ADD) begin errors++; $display("FAIL reset_opcode: got %0d want %0d", alu_opcode, OP_ADD); end
        checks++;
        if ({srcA, srcB, store_data, rd_addr} !== '0) begin
            errors++; $display("FAIL reset_data: got a=%h b=%h sd=%h rd=%0d want all 0", srcA, srcB, store_data, rd_addr);
        end
        checks++;
        if ({rd_we, is_branch, is_jump, mem_read, mem_write, illegal} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000",
                               {rd_we, is_branch, is_jump, mem_read, mem_write, illegal});
        end
        track = 1;
    endtask

    task automatic test_alu();
        out_ready = 1; in_valid = 1; instr = 32'h002081B3; rs1_data = 5; rs2_data = 7; pc = 32'h200;
        #1;
        checks++;
        if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin
            errors++; $display("FAIL rs_addr: got %0d,%0d want 1,2", rs1_addr, rs2_addr);
        end
        step();
        checks++;
        if (out_valid !== 1 || alu_opcode !== OP_ADD || srcA !== 32'd5 || srcB !== 32'd7 || rd_addr !== 5'd3 || rd_we !== 1) begin
            errors++; $display("FAIL add: got v=%b op=%0d a=%0d b=%0d rd=%0d we=%b want 1 0 5 7 3 1",
                               out_valid, alu_opcode, srcA, srcB, rd_addr, rd_we);
        end
        instr = 32'h40435293; rs1_data = 32'h8000_0000;
        step();
        checks++;
        if (alu_opcode !== OP_SRA || srcB !== 32'd4 || srcA !== 32'h8000_0000 || rd_addr !== 5'd5) begin
            errors++; $display("FAIL srai: got op=%0d a=%h b=%h rd=%0d want 7 80000000 4 5", alu_opcode, srcA, srcB, rd_addr);
        end
        instr = 32'hFFF00093; rs1_data = 0;
        step();
        in_valid = 0;
        checks++;
        if (alu_opcode !== OP_ADD || srcB !== 32'hFFFF_FFFF || rd_we !== 1) begin
            errors++; $display("FAIL addi_neg: got op=%0d b=%h we=%b want 0 ffffffff 1", alu_opcode, srcB, rd_we);
        end
        step();
    endtask

    task automatic test_branch_jump();
        out_ready = 1; in_valid = 1; instr = 32'h0020E063; rs1_data = 1; rs2_data = 2; pc = 32'h80;
        step();
        checks++;
        if (alu_opcode !== OP_BLTU || is_branch !== 1 || rd_we !== 0 || srcA !== 1 || srcB !== 2) begin
            errors++; $display("FAIL bltu: got op=%0d br=%b we=%b a=%0d b=%0d want 14 1 0 1 2",
                               alu_opcode, is_branch, rd_we, srcA, srcB);
        end
        instr = 32'h000000EF; pc = 32'h100;
        step();
        in_valid = 0;
        checks++;
        if (srcA !== 32'h100 || srcB !== 32'd4 || is_jump !== 1 || rd_we !== 1 || rd_addr !== 5'd1 || alu_opcode !== OP_ADD) begin
            errors++; $display("FAIL jal: got a=%h b=%0d j=%b we=%b rd=%0d op=%0d want 100 4 1 1 1 0",
                               srcA, srcB, is_jump, rd_we, rd_addr, alu_opcode);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int next_tag = 1;
        int want = 1;
        in_valid = 1; flush = 0; rs1_data = 0; rs2_data = 0; pc = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            instr = {12'(next_tag), 5'd0, 3'd0, 5'd1, 7'h13};
            #1;
            if (c == 3 || c == 4 || c == 5) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); end
            end
            if (c == 4) begin
                checks++;
                if (out_valid !== 1 || srcB !== 32'd2) begin
                    errors++; $display("FAIL stall_hold: got v=%b b=%0d want 1 2", out_valid, srcB);
                end
            end
            if (c == 5) begin
                checks++;
                if (next_tag != 4) begin errors++; $display("FAIL stall_accepts: got %0d accepted want 3", next_tag - 1); end
            end
            if (c == 6) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (srcB !== 32'(want)) begin errors++; $display("FAIL order: got tag %0d want %0d", srcB, want); end
                want++;
            end
            if (in_ready === 1'b1) next_tag++;
            step();
        end
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (srcB !== 32'(want)) begin errors++; $display("FAIL order_drain: got tag %0d want %0d", srcB, want); end
                want++;
            end
            step();
        end
        checks++;
        if (want != next_tag) begin errors++; $display("FAIL delivered_count: got %0d want %0d", want - 1, next_tag - 1); end
    endtask

    task automatic test_flush();
        int n = 0;
        out_ready = 0; in_valid = 1; flush = 0;
        while (in_ready === 1'b1 && n < 8) begin
            instr = {12'(50 + n), 5'd0, 3'd0, 5'd2, 7'h13};
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_fill: in_ready got %b want 0 within 8 cycles", in_ready); end
        flush = 1; instr = {12'd99, 5'd0, 3'd0, 5'd2, 7'h13};
        step();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost c%0d: out_valid got %b want 0", c, out_valid); end
            step();
        end
    endtask

    task automatic test_illegal();
        out_ready = 1; in_valid = 1; instr = 32'h000001FF; rs1_data = $urandom; rs2_data = $urandom; pc = 32'h300;
        step();
        in_valid = 0;
        checks++;
        if (out_valid !== 1 || illegal !== ILL_EN || rd_we !== 0 || alu_opcode !== OP_ADD || srcA !== 0 || srcB !== 0) begin
            errors++; $display("FAIL illegal: got v=%b ill=%b we=%b op=%0d a=%h b=%h want 1 %b 0 0 0 0",
                               out_valid, illegal, rd_we, alu_opcode, srcA, srcB, ILL_EN);
        end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            instr     = rand_instr();
            pc        = $urandom;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            step();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch_jump();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
